// File: rtl/acc_pipe_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_pipe_core_if
//  Purpose  : Harvard memory bundle of acc_pipe_core. Port 0 is the
//             combinational-read instruction SRAM, port 1 is the
//             combinational-read / edge-write data SRAM.
//  Revision : 1.0  initial release
// ============================================================================
interface acc_pipe_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] inst_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  we_n;

    // Core side
    modport master (
        input  inst_in, data_in,
        output addr_0, addr_1, data_out, we_n
    );

    // Memory side
    modport slave (
        output inst_in, data_in,
        input  addr_0, addr_1, data_out, we_n
    );
endinterface
`default_nettype wire

// File: rtl/acc_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module   : acc_pipe_core
//  Purpose  : Three-stage (IF -> OF -> EX) pipelined accumulator CPU for the
//             16-bit basic-computer instruction set, with interlocks,
//             branch/skip flushing, multi-cycle indirect addressing and HLT.
//  Revision : 1.0  initial release
// ============================================================================
module acc_pipe_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int PC_RESET   = 0
) (
    input  wire                    clk,
    input  wire                    reset,
    acc_pipe_core_if.master        mem,
    output logic                   halted,
    output logic [DATA_WIDTH-1:0]  ac_out,
    output logic                   e_out,
    output logic                   retire
);
    localparam logic [2:0] c_OP_AND = 3'd0;
    localparam logic [2:0] c_OP_ADD = 3'd1;
    localparam logic [2:0] c_OP_LDA = 3'd2;
    localparam logic [2:0] c_OP_STA = 3'd3;
    localparam logic [2:0] c_OP_BUN = 3'd4;
    localparam logic [2:0] c_OP_BSA = 3'd5;
    localparam logic [2:0] c_OP_ISZ = 3'd6;
    localparam logic [2:0] c_OP_RR  = 3'd7;

    // Architectural and pipeline state
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] ac_q;
    logic                  e_q, halted_q, retire_q;
    logic                  of_valid_q, of_ind_done_q;
    logic [DATA_WIDTH-1:0] of_inst_q;
    logic [ADDR_WIDTH-1:0] of_pc_q, of_ea_q;
    logic                  ex_valid_q;
    logic [DATA_WIDTH-1:0] ex_inst_q, ex_opnd_q;
    logic [ADDR_WIDTH-1:0] ex_pc_q, ex_ea_q;

    // ---------------- OF decode ----------------
    logic [2:0]            w_of_op;
    logic                  w_of_need_ind, w_of_need_opnd, w_of_reads;
    logic                  w_of_exit, w_of_accept, w_stall;
    logic [ADDR_WIDTH-1:0] w_of_ea, w_of_rd_addr;

    assign w_of_op        = of_inst_q[DATA_WIDTH-2:DATA_WIDTH-4];
    assign w_of_need_ind  = of_valid_q && (w_of_op != c_OP_RR) &&
                            of_inst_q[DATA_WIDTH-1] && !of_ind_done_q;
    assign w_of_need_opnd = (w_of_op == c_OP_AND) || (w_of_op == c_OP_ADD) ||
                            (w_of_op == c_OP_LDA) || (w_of_op == c_OP_ISZ);
    assign w_of_ea        = of_ind_done_q ? of_ea_q : of_inst_q[ADDR_WIDTH-1:0];
    assign w_of_reads     = w_of_need_ind || (of_valid_q && w_of_need_opnd);
    assign w_of_rd_addr   = w_of_need_ind ? of_inst_q[ADDR_WIDTH-1:0] : w_of_ea;

    // ---------------- EX decode ----------------
    logic [2:0]            w_ex_op;
    logic                  w_ex_wr, w_wr_en;
    logic [DATA_WIDTH-1:0] w_ac_d, w_wdata, w_isz_res;
    logic                  w_e_d, w_redirect, w_hlt;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_ex_op   = ex_inst_q[DATA_WIDTH-2:DATA_WIDTH-4];
    assign w_ex_wr   = ex_valid_q && ((w_ex_op == c_OP_STA) ||
                       (w_ex_op == c_OP_BSA) || (w_ex_op == c_OP_ISZ));
    // A write whose commit edge coincides with reset is dropped.
    assign w_wr_en   = w_ex_wr && !reset;
    assign w_isz_res = ex_opnd_q + DATA_WIDTH'(1);

    // The EX write owns the data port, so any OF read waits a cycle.
    assign w_stall     = w_ex_wr && w_of_reads;
    assign w_of_exit   = of_valid_q && !w_of_need_ind && !w_stall;
    assign w_of_accept = !of_valid_q || w_of_exit;

    // EX stage: next AC/E, write data, redirect and halt decisions
    always_comb begin
        w_ac_d     = ac_q;
        w_e_d      = e_q;
        w_wdata    = '0;
        w_redirect = 1'b0;
        w_hlt      = 1'b0;
        w_target   = ex_pc_q + ADDR_WIDTH'(2);
        if (ex_valid_q) begin
            case (w_ex_op)
                c_OP_AND: w_ac_d = ac_q & ex_opnd_q;
                c_OP_ADD: {w_e_d, w_ac_d} = {1'b0, ac_q} + {1'b0, ex_opnd_q};
                c_OP_LDA: w_ac_d = ex_opnd_q;
                c_OP_STA: w_wdata = ac_q;
                c_OP_BUN: begin
                    w_redirect = 1'b1;
                    w_target   = ex_ea_q;
                end
                c_OP_BSA: begin
                    w_wdata    = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, ex_pc_q + ADDR_WIDTH'(1)};
                    w_redirect = 1'b1;
                    w_target   = ex_ea_q + ADDR_WIDTH'(1);
                end
                c_OP_ISZ: begin
                    w_wdata    = w_isz_res;
                    w_redirect = (w_isz_res == '0);
                end
                default: begin
                    // I/O space (I=1) is a NOP; register-reference needs one hot bit.
                    if (!ex_inst_q[DATA_WIDTH-1]) begin
                        case (ex_inst_q[11:0])
                            12'h800: w_ac_d = '0;
                            12'h400: w_e_d  = 1'b0;
                            12'h200: w_ac_d = ~ac_q;
                            12'h100: w_e_d  = ~e_q;
                            12'h080: begin
                                w_ac_d = {e_q, ac_q[DATA_WIDTH-1:1]};
                                w_e_d  = ac_q[0];
                            end
                            12'h040: begin
                                w_ac_d = {ac_q[DATA_WIDTH-2:0], e_q};
                                w_e_d  = ac_q[DATA_WIDTH-1];
                            end
                            12'h020: w_ac_d     = ac_q + DATA_WIDTH'(1);
                            12'h010: w_redirect = !ac_q[DATA_WIDTH-1];
                            12'h008: w_redirect = ac_q[DATA_WIDTH-1];
                            12'h004: w_redirect = (ac_q == '0);
                            12'h002: w_redirect = !e_q;
                            12'h001: w_hlt      = 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Pipeline advance: EX completion first, then OF -> EX, then IF -> OF
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= ADDR_WIDTH'(PC_RESET);
            ac_q          <= '0;
            e_q           <= 1'b0;
            halted_q      <= 1'b0;
            retire_q      <= 1'b0;
            of_valid_q    <= 1'b0;
            of_ind_done_q <= 1'b0;
            of_inst_q     <= '0;
            of_pc_q       <= '0;
            of_ea_q       <= '0;
            ex_valid_q    <= 1'b0;
            ex_inst_q     <= '0;
            ex_opnd_q     <= '0;
            ex_pc_q       <= '0;
            ex_ea_q       <= '0;
        end else begin
            retire_q <= ex_valid_q;
            ac_q     <= w_ac_d;
            e_q      <= w_e_d;
            if (w_hlt) begin
                // PC stays where it is; younger work is discarded.
                halted_q   <= 1'b1;
                of_valid_q <= 1'b0;
                ex_valid_q <= 1'b0;
            end else if (w_redirect) begin
                // Flush wins over any stall in the same cycle.
                pc_q       <= w_target;
                of_valid_q <= 1'b0;
                ex_valid_q <= 1'b0;
            end else begin
                ex_valid_q <= w_of_exit;
                if (w_of_exit) begin
                    ex_inst_q <= of_inst_q;
                    ex_pc_q   <= of_pc_q;
                    ex_ea_q   <= w_of_ea;
                    ex_opnd_q <= mem.data_in;
                end
                if (w_of_accept) begin
                    of_valid_q <= !halted_q;
                    if (!halted_q) begin
                        of_inst_q     <= mem.inst_in;
                        of_pc_q       <= pc_q;
                        of_ind_done_q <= 1'b0;
                        pc_q          <= pc_q + ADDR_WIDTH'(1);
                    end
                end else if (w_of_need_ind && !w_stall) begin
                    of_ind_done_q <= 1'b1;
                    of_ea_q       <= mem.data_in[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    assign mem.addr_0   = pc_q;
    assign mem.addr_1   = w_ex_wr    ? ex_ea_q :
                          w_of_reads ? w_of_rd_addr : '0;
    assign mem.data_out = w_wr_en ? w_wdata : '0;
    assign mem.we_n     = !w_wr_en;

    assign halted = halted_q;
    assign ac_out = ac_q;
    assign e_out  = e_q;
    assign retire = retire_q;
endmodule
`default_nettype wire

// File: tb/tb_acc_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_pipe_core
//  Purpose  : Self-checking bench for acc_pipe_core: directed programs with
//             hand-derived timing plus random programs checked against an
//             instruction-level reference interpreter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_pipe_core;
    logic clk;
    logic reset_a, reset_b;
    logic halted_a, e_a, retire_a, halted_b, e_b, retire_b;
    logic [15:0] ac_a;
    logic [23:0] ac_b;

    logic [15:0] imem_a [0:4095];
    logic [15:0] dmem_a [0:4095];
    logic [23:0] imem_b [0:65535];
    logic [23:0] dmem_b [0:65535];

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int rq[$];
    int exp_q[$];

    // reference interpreter state
    logic [15:0] rmem [0:4095];
    logic [15:0] r_ac;
    logic        r_e, r_halt;
    int          r_cnt;

    acc_pipe_core_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus_a ();
    acc_pipe_core_if #(.DATA_WIDTH(24), .ADDR_WIDTH(16)) bus_b ();

    assign bus_a.inst_in = imem_a[bus_a.addr_0];
    assign bus_a.data_in = dmem_a[bus_a.addr_1];
    assign bus_b.inst_in = imem_b[bus_b.addr_0];
    assign bus_b.data_in = dmem_b[bus_b.addr_1];

    acc_pipe_core #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .PC_RESET(0)) u_a (
        .clk(clk), .reset(reset_a), .mem(bus_a),
        .halted(halted_a), .ac_out(ac_a), .e_out(e_a), .retire(retire_a)
    );

    acc_pipe_core #(.DATA_WIDTH(24), .ADDR_WIDTH(16), .PC_RESET(0)) u_b (
        .clk(clk), .reset(reset_b), .mem(bus_b),
        .halted(halted_b), .ac_out(ac_b), .e_out(e_b), .retire(retire_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture any write requested before the edge, commit it after.
    task automatic step();
        logic        wa, wb;
        logic [11:0] aa;
        logic [15:0] da, ab;
        logic [23:0] db;
        #1;
        wa = !bus_a.we_n; aa = bus_a.addr_1; da = bus_a.data_out;
        wb = !bus_b.we_n; ab = bus_b.addr_1; db = bus_b.data_out;
        @(posedge clk);
        #1;
        if (wa) dmem_a[aa] = da;
        if (wb) dmem_b[ab] = db;
        cyc++;
        if (retire_a) rq.push_back(cyc);
    endtask

    task automatic clr_a();
        for (int i = 0; i < 4096; i++) begin
            imem_a[i] = 16'h0000;
            dmem_a[i] = 16'h0000;
        end
    endtask

    task automatic run_a(input string tag, input int max_cyc);
        reset_a = 1'b1;
        step();
        step();
        reset_a = 1'b0;
        cyc = 0;
        rq.delete();
        while (!halted_a && cyc < max_cyc) step();
        chk({tag, "_halted"}, halted_a, 1'b1);
    endtask

    task automatic chk_retires(input string tag);
        chk({tag, "_nret"}, rq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rq.size(); i++)
            chk($sformatf("%s_ret%0d", tag, i), rq[i], exp_q[i]);
    endtask

    // Instruction-level interpreter of imem_a over rmem, starting at PC 0.
    task automatic ref_run();
        logic [11:0] pc, pcn, ea;
        logic [15:0] ins;
        logic [16:0] sum;
        logic [2:0]  op;
        pc = 12'h000; r_ac = 16'h0; r_e = 1'b0; r_halt = 1'b0; r_cnt = 0;
        for (int n = 0; n < 200 && !r_halt; n++) begin
            ins = imem_a[pc];
            op  = ins[14:12];
            pcn = pc + 12'd1;
            r_cnt++;
            if (op != 3'd7) begin
                ea = ins[11:0];
                if (ins[15]) ea = rmem[ea][11:0];
                case (op)
                    3'd0: r_ac = r_ac & rmem[ea];
                    3'd1: begin sum = {1'b0, r_ac} + {1'b0, rmem[ea]}; r_ac = sum[15:0]; r_e = sum[16]; end
                    3'd2: r_ac = rmem[ea];
                    3'd3: rmem[ea] = r_ac;
                    3'd4: pcn = ea;
                    3'd5: begin rmem[ea] = {4'h0, pc + 12'd1}; pcn = ea + 12'd1; end
                    default: begin
                        rmem[ea] = rmem[ea] + 16'd1;
                        if (rmem[ea] == 16'h0) pcn = pc + 12'd2;
                    end
                endcase
            end else if (!ins[15]) begin
                case (ins[11:0])
                    12'h800: r_ac = 16'h0;
                    12'h400: r_e = 1'b0;
                    12'h200: r_ac = ~r_ac;
                    12'h100: r_e = ~r_e;
                    12'h080: {r_ac, r_e} = {r_e, r_ac};
                    12'h040: {r_e, r_ac} = {r_ac, r_e};
                    12'h020: r_ac = r_ac + 16'd1;
                    12'h010: if (!r_ac[15]) pcn = pc + 12'd2;
                    12'h008: if (r_ac[15]) pcn = pc + 12'd2;
                    12'h004: if (r_ac == 16'h0) pcn = pc + 12'd2;
                    12'h002: if (!r_e) pcn = pc + 12'd2;
                    12'h001: r_halt = 1'b1;
                    default: ;
                endcase
            end
            pc = pcn;
        end
    endtask

    initial begin
        logic [15:0] da0, da1;
        int k, t, bitn;
        logic [2:0] mops [0:4];
        mops[0] = 3'd0; mops[1] = 3'd1; mops[2] = 3'd2; mops[3] = 3'd3; mops[4] = 3'd6;
        reset_a = 1'b1;
        reset_b = 1'b1;
        cyc = 0;
        clr_a();
        for (int i = 0; i < 65536; i++) begin
            imem_b[i] = 24'h0;
            dmem_b[i] = 24'h0;
        end
        @(posedge clk);

        // ---- Reset state ----
        step();
        step();
        chk("rst_addr0", bus_a.addr_0, 12'h000);
        chk("rst_we_n", bus_a.we_n, 1'b1);
        chk("rst_halted", halted_a, 1'b0);
        chk("rst_ac", ac_a, 16'h0);
        chk("rst_e", e_a, 1'b0);
        chk("rst_retire", retire_a, 1'b0);
        chk("rst_dout", bus_a.data_out, 16'h0);

        // ---- LDA/ADD/STA/HLT, normal and carry-out data ----
        for (int v = 0; v < 2; v++) begin
            clr_a();
            da0 = (v == 0) ? 16'h0005 : 16'hFFFF;
            da1 = (v == 0) ? 16'h0003 : 16'h0001;
            imem_a[0] = 16'h2010; imem_a[1] = 16'h1011;
            imem_a[2] = 16'h3012; imem_a[3] = 16'h7001;
            dmem_a[12'h010] = da0; dmem_a[12'h011] = da1;
            run_a($sformatf("basic%0d", v), 40);
            chk($sformatf("basic%0d_m012", v), dmem_a[12'h012], (v == 0) ? 16'h0008 : 16'h0000);
            chk($sformatf("basic%0d_ac", v), ac_a, (v == 0) ? 16'h0008 : 16'h0000);
            chk($sformatf("basic%0d_e", v), e_a, (v == 0) ? 1'b0 : 1'b1);
            exp_q = '{3, 4, 5, 6};
            chk_retires($sformatf("basic%0d", v));
        end

        // ---- Indirect LDA then CMA ----
        clr_a();
        imem_a[0] = 16'hA020; imem_a[1] = 16'h7200; imem_a[2] = 16'h7001;
        dmem_a[12'h020] = 16'h0030; dmem_a[12'h030] = 16'hABCD;
        run_a("ind", 40);
        chk("ind_ac", ac_a, 16'h5432);
        exp_q = '{4, 5, 6};
        chk_retires("ind");

        // ---- BUN flushes two CLAs ----
        clr_a();
        imem_a[0] = 16'h4040; imem_a[1] = 16'h7800; imem_a[2] = 16'h7800;
        imem_a[12'h040] = 16'h7200; imem_a[12'h041] = 16'h7001;
        run_a("bun", 40);
        chk("bun_ac", ac_a, 16'hFFFF);
        exp_q = '{3, 6, 7};
        chk_retires("bun");

        // ---- ISZ wrap with skip, and ISZ without skip ----
        for (int v = 0; v < 2; v++) begin
            clr_a();
            imem_a[0] = 16'h6050; imem_a[1] = 16'h7200; imem_a[2] = 16'h7001;
            dmem_a[12'h050] = (v == 0) ? 16'hFFFF : 16'h0001;
            run_a($sformatf("isz%0d", v), 40);
            chk($sformatf("isz%0d_m050", v), dmem_a[12'h050], (v == 0) ? 16'h0000 : 16'h0002);
            chk($sformatf("isz%0d_ac", v), ac_a, (v == 0) ? 16'h0000 : 16'hFFFF);
            if (v == 0) exp_q = '{3, 6};
            else        exp_q = '{3, 4, 5};
            chk_retires($sformatf("isz%0d", v));
        end

        // ---- STA then LDA of same address: one-cycle port stall ----
        clr_a();
        imem_a[0] = 16'h2061; imem_a[1] = 16'h7200; imem_a[2] = 16'h3060;
        imem_a[3] = 16'h2060; imem_a[4] = 16'h7001;
        dmem_a[12'h061] = 16'hEDCB;
        run_a("raw", 40);
        chk("raw_ac", ac_a, 16'h1234);
        chk("raw_m060", dmem_a[12'h060], 16'h1234);
        exp_q = '{3, 4, 5, 7, 8};
        chk_retires("raw");

        // ---- BSA 070 from PC 005 ----
        clr_a();
        for (int i = 0; i < 5; i++) imem_a[i] = 16'h7000;
        imem_a[5] = 16'h5070; imem_a[6] = 16'h7200;
        imem_a[12'h071] = 16'h7020; imem_a[12'h072] = 16'h7001;
        run_a("bsa", 60);
        chk("bsa_m070", dmem_a[12'h070], 16'h0006);
        chk("bsa_ac", ac_a, 16'h0001);
        exp_q = '{3, 4, 5, 6, 7, 8, 11, 12};
        chk_retires("bsa");

        // ---- Reset during the STA write cycle ----
        clr_a();
        imem_a[0] = 16'h7200; imem_a[1] = 16'h3080; imem_a[2] = 16'h7001;
        dmem_a[12'h080] = 16'h5555;
        reset_a = 1'b1;
        step();
        step();
        reset_a = 1'b0;
        cyc = 0;
        step(); step(); step();
        chk("rstw_pre_we_n", bus_a.we_n, 1'b0);
        chk("rstw_pre_addr1", bus_a.addr_1, 12'h080);
        reset_a = 1'b1;
        #1;
        chk("rstw_we_n", bus_a.we_n, 1'b1);
        chk("rstw_dout", bus_a.data_out, 16'h0);
        step();
        chk("rstw_mem", dmem_a[12'h080], 16'h5555);
        chk("rstw_addr0", bus_a.addr_0, 12'h000);
        chk("rstw_ac", ac_a, 16'h0);
        chk("rstw_retire", retire_a, 1'b0);
        reset_a = 1'b0;

        // ---- Wide instance: 24-bit ADD carry ----
        imem_b[0] = 24'h200100; imem_b[1] = 24'h100101; imem_b[2] = 24'h700001;
        dmem_b[16'h0100] = 24'hFFFFFF; dmem_b[16'h0101] = 24'h000001;
        step();
        reset_b = 1'b0;
        k = 0;
        while (!halted_b && k < 40) begin step(); k++; end
        chk("w24_halted", halted_b, 1'b1);
        chk("w24_ac", ac_b, 24'h000000);
        chk("w24_e", e_b, 1'b1);

        // ---- Random forward-only programs vs. the interpreter ----
        for (int p = 0; p < 20; p++) begin
            clr_a();
            for (int a = 12'h100; a < 12'h110; a++) dmem_a[a] = 16'($urandom);
            for (int a = 12'h1F0; a < 12'h1F4; a++) dmem_a[a] = 16'h100 | 16'($urandom_range(0, 15));
            for (int pc = 0; pc < 16; pc++) begin
                k = $urandom_range(0, 9);
                if (k <= 5) begin
                    t = $urandom_range(0, 1);
                    imem_a[pc] = {t[0], mops[$urandom_range(0, 4)],
                                  (t == 1) ? 12'(12'h1F0 + $urandom_range(0, 3))
                                           : 12'(12'h100 + $urandom_range(0, 15))};
                end else if (k == 6) begin
                    imem_a[pc] = 16'h4000 | 16'($urandom_range(pc + 1, 16));
                end else if (k == 7 && pc < 15) begin
                    imem_a[pc] = 16'h5000 | 16'($urandom_range(pc + 1, 15));
                end else begin
                    bitn = $urandom_range(1, 13);
                    if (bitn == 12)      imem_a[pc] = 16'h7000;
                    else if (bitn == 13) imem_a[pc] = 16'hF000;
                    else                 imem_a[pc] = 16'h7000 | 16'(1 << bitn);
                end
            end
            imem_a[16] = 16'h7001;
            imem_a[17] = 16'h7001;
            for (int a = 0; a < 4096; a++) rmem[a] = dmem_a[a];
            ref_run();
            run_a($sformatf("rnd%0d", p), 300);
            chk($sformatf("rnd%0d_ac", p), ac_a, r_ac);
            chk($sformatf("rnd%0d_e", p), e_a, r_e);
            chk($sformatf("rnd%0d_nret", p), rq.size(), r_cnt);
            for (int a = 0; a < 16; a++) begin
                chk($sformatf("rnd%0d_m%03h", p, a), dmem_a[a], rmem[a]);
                chk($sformatf("rnd%0d_m%03h", p, a + 256), dmem_a[a + 256], rmem[a + 256]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/acc_pipe_core.md
# acc_pipe_core

Parametrised three-stage pipelined accumulator CPU (IF → OF → EX) executing the team's 16-bit basic-computer instruction set over generic data and address widths. It connects to a combinational-read instruction SRAM on port 0 and a combinational-read data SRAM on port 1 (Harvard). It is the successor to the five-stage prototype, adding:
- hazard interlocks
- branch/skip flushing
- multi-cycle indirect addressing
- HLT
- a verification-visible architectural state port

## Interface
Parameters:
- DATA_WIDTH, 16, instruction and data word width; must be ≥ 16.
- ADDR_WIDTH, 12, memory address width; must be ≤ DATA_WIDTH-4.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- inst_in  in  DATA_WIDTH  instruction-SRAM read data for addr_0, valid in the same cycle.
- data_in  in  DATA_WIDTH  data-SRAM read data for addr_1, valid in the same cycle.
- addr_0  out  ADDR_WIDTH  instruction fetch address (= PC).
- addr_1  out  ADDR_WIDTH  data-SRAM address (read or write).
- data_out  out  DATA_WIDTH  data-SRAM write data.
- we_n  out  1  data-SRAM write enable, active-low; write commits at the rising edge.
- halted  out  1  high after HLT retires.
- ac_out  out  DATA_WIDTH  current AC.
- e_out  out  1  current E.
- retire  out  1  one-cycle pulse per retired instruction.

## Operation
Instruction fields:
- Bit [DATA_WIDTH-1] = I (indirect).
- Bits [DATA_WIDTH-2:DATA_WIDTH-4] = opcode.
- Bits [ADDR_WIDTH-1:0] = address.
- Opcode 7 is register-reference (I=0) or I/O (I=1). Register-reference decode uses bits [11:0].

Memory-reference opcodes:
- 0 AND: AC &= M[EA].
- 1 ADD: {E,AC} = AC + M[EA]. Carry out of the DATA_WIDTH add goes to E.
- 2 LDA: AC = M[EA].
- 3 STA: M[EA] = AC.
- 4 BUN: PC = EA.
- 5 BSA: M[EA] = return PC (instruction PC+1, truncated to ADDR_WIDTH and zero-extended); PC = EA+1, wrapping modulo 2^ADDR_WIDTH.
- 6 ISZ: M[EA] = M[EA]+1, wrapping; skip if the result is 0.

Register-reference bits (exactly one set; any other value is a NOP):
- 800 CLA, 400 CLE, 200 CMA, 100 CME.
- 080 CIR: {AC,E} rotate right.
- 040 CIL: {AC,E} rotate left.
- 020 INC: AC+1 wraps, E unchanged.
- 010 SPA: skip if AC[MSB]=0.
- 008 SNA: skip if AC[MSB]=1.
- 004 SZA: skip if AC=0.
- 002 SZE: skip if E=0.
- 001 HLT.
- Opcode 7 with I=1 (I/O) is a NOP.

Stages:
- IF: latches inst_in and the PC into the OF register; PC += 1 (wraps).
- OF: resolves EA and the operand.
  - Direct: EA = address field.
  - Indirect: first cycle reads M[address]; EA = data_in[ADDR_WIDTH-1:0]. IF holds during this cycle.
  - AND/ADD/LDA/ISZ then read M[EA] (one more cycle). Other opcodes need no operand read.
  - An instruction exits OF the cycle its last read completes, or immediately if it needs no read.
- EX: executes; STA/BSA/ISZ drive we_n=0, addr_1=EA and data_out for exactly one cycle.
  - Taken BUN/BSA/skip redirects the PC: the branch target, or EX PC+2 for skips. The IF and OF stages are flushed (valid bits cleared).
  - HLT retires, sets halted, flushes younger instructions, and freezes PC; halted is cleared only by reset.

Data-port arbitration:
- An EX write owns addr_1 in that cycle; any OF read stalls one cycle (OF and IF hold).
- Read-after-write is safe by construction: an OF read of the same address always occurs after the write edge.

Idle defaults: addr_1 = OF's pending read address, else 0; data_out = 0 when not writing; we_n = 1.

Reset values (while reset is high, and the cycle after):
- PC = PC_RESET, AC = 0, E = 0, all stage valid bits = 0.
- we_n = 1, halted = 0, retire = 0, data_out = 0.

Reset asserted mid-operation aborts every in-flight instruction, including a write that has not yet committed. A write whose edge coincides with reset is suppressed (we_n forced to 1).

## Timing
- Straight-line direct non-memory instructions retire one per cycle after a 2-cycle fill. First retire pulse occurs on the 3rd rising edge after reset release.
- Latency IF→retire per instruction:
  - 3 cycles for instructions needing no operand read.
  - +1 cycle per data read beyond the first (indirect operand read = 2 reads).
  - +1 cycle per write-port conflict stall.
- Taken branch or skip: 2-cycle bubble. PC update and flush happen on the same edge as EX completion.
- Simultaneous events: a flush and a stall in the same cycle resolve as flush wins. A write and an OF indirect read in the same cycle resolve as write wins.
- ADD with AC=FFFF, M=0001 gives AC=0000, E=1. ISZ on FFFF writes 0000 and skips.
- PC wraps from 2^ADDR_WIDTH-1 to 0.

## Test plan
- Reset → addr_0=000, we_n=1, halted=0, ac_out=0. Program LDA 010; ADD 011; STA 012; HLT, with M[010]=0005, M[011]=0003 → M[012]=0008, halted=1, 4 retire pulses.
- Indirect LDA via M[020]=0030, M[030]=ABCD → ac_out=ABCD; younger instructions hold exactly 1 extra cycle.
- BUN 040 followed by two CLA instructions → both CLA never retire; next retire is from PC 040; bubble = 2 cycles.
- ISZ on M[050]=FFFF → M[050]=0000 written, the next instruction is skipped. ISZ on M[050]=0001 → 0002 written, no skip.
- STA 060 immediately followed by LDA 060 with AC=1234 → LDA stalls 1 cycle, AC=1234; BSA 070 at PC 005 writes 0006 to M[070] and fetches next from 071.
- Reset asserted during the EX write cycle of STA → we_n stays 1, memory is unchanged, PC returns to PC_RESET. With DATA_WIDTH=24, ADDR_WIDTH=16, ADD FFFFFF+1 → AC=000000, E=1.
